// File: rtl/phase_sequencer_pkg.sv
// phase_pkg: shared FSM encoding, mode constants and one-hot helper for the phase sequencer.
package phase_pkg;
  typedef enum logic {RUN, HALTED} fsm_e;
  localparam logic MODE_FREE = 1'b0;
  localparam logic MODE_STEP = 1'b1;
  localparam int MAX_PHASES = 16;
  function automatic logic [MAX_PHASES-1:0] onehot(input int idx, input int n);
    return (idx < n) ? MAX_PHASES'(1) << idx : '0;
  endfunction
endpackage

// File: rtl/phase_sequencer_edge_detect.sv
// edge_detect: rising-edge detector with asynchronous active-low reset.
module edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);
  logic d_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) d_q <= 1'b0;
    else d_q <= d_i;
  assign rise_o = d_i & ~d_q;
endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer: rotating one-hot phase enables with stall, boundary halt, single-step and instruction counter.
module phase_sequencer
  import phase_pkg::*;
#(
  parameter int NUM_PHASES   = 3,
  parameter int STATE_W      = $clog2(NUM_PHASES),
  parameter int CNT_W        = 16,
  parameter bit START_HALTED = 1'b0
) (
  input  logic                  i_CLOCK,
  input  logic                  i_RESETn,
  input  logic                  i_MODE,
  input  logic                  i_STEP,
  input  logic                  i_HALT_REQ,
  input  logic                  i_STALL,
  output logic [NUM_PHASES-1:0] o_PHASE,
  output logic [STATE_W-1:0]    o_STATE,
  output logic                  o_LAST,
  output logic                  o_HALTED,
  output logic [CNT_W-1:0]      o_ICOUNT
);
  if (NUM_PHASES < 2 || NUM_PHASES > MAX_PHASES) begin : g_bad_phases
    $error("phase_sequencer: NUM_PHASES must be in 2..16");
  end
  fsm_e fsm_q, fsm_d;
  logic [STATE_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] icount_q, icount_d;
  logic run, last_idx, boundary, step_rise;
  edge_detect u_step_edge (
    .clk_i  (i_CLOCK),
    .rst_ni (i_RESETn),
    .d_i    (i_STEP),
    .rise_o (step_rise)
  );
  // Mode and halt request only matter at the boundary or while halted, so an instruction always completes.
  always_comb begin
    run      = fsm_q == RUN;
    last_idx = idx_q == STATE_W'(NUM_PHASES - 1);
    boundary = run & ~i_STALL & last_idx;
    idx_d    = (run & ~i_STALL) ? (last_idx ? '0 : idx_q + STATE_W'(1)) : idx_q;
    icount_d = icount_q + CNT_W'(boundary);
    fsm_d    = run ? ((boundary && (i_HALT_REQ || i_MODE == MODE_STEP)) ? HALTED : RUN)
                   : ((!i_HALT_REQ && (i_MODE == MODE_FREE || step_rise)) ? RUN : HALTED);
  end
  always_ff @(posedge i_CLOCK or negedge i_RESETn)
    if (!i_RESETn) begin
      fsm_q    <= START_HALTED ? HALTED : RUN;
      idx_q    <= '0;
      icount_q <= '0;
    end else begin
      fsm_q    <= fsm_d;
      idx_q    <= idx_d;
      icount_q <= icount_d;
    end
  assign o_PHASE  = run ? NUM_PHASES'(onehot(int'(idx_q), NUM_PHASES)) : '0;
  assign o_STATE  = run ? idx_q : '0;
  assign o_HALTED = ~run;
  assign o_LAST   = boundary;
  assign o_ICOUNT = icount_q;
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: drives a 3-phase and a 5-phase/2-bit-counter/start-halted sequencer against a behavioural model.
module tb_phase_sequencer;
  logic clk = 1'b0;
  logic rst_n, mode, step, halt, stall;
  logic [2:0] p3;
  logic [1:0] s3;
  logic l3, h3;
  logic [15:0] c3;
  logic [4:0] p5;
  logic [2:0] s5;
  logic l5, h5;
  logic [1:0] c5;
  int checks = 0;
  int failures = 0;
  int n[2] = '{3, 5};
  int cmod[2] = '{65536, 4};
  bit sh[2] = '{1'b0, 1'b1};
  int ph[2], cnt[2];
  bit run[2], ps[2];

  always #5 clk = ~clk;

  phase_sequencer #(.NUM_PHASES(3), .CNT_W(16), .START_HALTED(1'b0)) dut3 (
    .i_CLOCK(clk), .i_RESETn(rst_n), .i_MODE(mode), .i_STEP(step), .i_HALT_REQ(halt), .i_STALL(stall),
    .o_PHASE(p3), .o_STATE(s3), .o_LAST(l3), .o_HALTED(h3), .o_ICOUNT(c3));
  phase_sequencer #(.NUM_PHASES(5), .CNT_W(2), .START_HALTED(1'b1)) dut5 (
    .i_CLOCK(clk), .i_RESETn(rst_n), .i_MODE(mode), .i_STEP(step), .i_HALT_REQ(halt), .i_STALL(stall),
    .o_PHASE(p5), .o_STATE(s5), .o_LAST(l5), .o_HALTED(h5), .o_ICOUNT(c5));

  task automatic chk(input string nm, input logic [31:0] got, input int exp);
    checks++;
    if (got !== 32'(exp)) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0;
      cnt[i] = 0;
      ps[i] = 1'b0;
      run[i] = !sh[i];
    end
  endtask

  // An instruction is n phases; it ends only on an unstalled final phase, where the stop decision is made.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (run[i]) begin
        if (!stall) begin
          if (ph[i] == n[i] - 1) begin
            ph[i] = 0;
            cnt[i] = (cnt[i] + 1) % cmod[i];
            run[i] = !(halt || mode);
          end else ph[i] = ph[i] + 1;
        end
      end else if (!halt && (!mode || (step && !ps[i]))) run[i] = 1'b1;
      ps[i] = step;
    end
  endtask

  task automatic compare_all();
    chk("phase3", p3, run[0] ? (1 << ph[0]) : 0);
    chk("state3", s3, run[0] ? ph[0] : 0);
    chk("last3", l3, (run[0] && ph[0] == 2 && !stall) ? 1 : 0);
    chk("halted3", h3, run[0] ? 0 : 1);
    chk("icount3", c3, cnt[0]);
    chk("phase5", p5, run[1] ? (1 << ph[1]) : 0);
    chk("state5", s5, run[1] ? ph[1] : 0);
    chk("last5", l5, (run[1] && ph[1] == 4 && !stall) ? 1 : 0);
    chk("halted5", h5, run[1] ? 0 : 1);
    chk("icount5", c5, cnt[1]);
  endtask

  task automatic cycle();
    #1;
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wait_phase3(input int want);
    int k;
    for (k = 0; k < 40 && !(run[0] && ph[0] == want); k++) cycle();
    if (k == 40) chk("wait_phase3_timeout", 1, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mode = 1'b0; step = 1'b0; halt = 1'b0; stall = 1'b0;
    #12;
    chk("rst_phase3", p3, 1);
    chk("rst_last3", l3, 0);
    chk("rst_cnt3", c3, 0);
    chk("rst_halted5", h5, 1);
    chk("rst_phase5", p5, 0);
    model_reset();
    rst_n = 1'b1;
    repeat (12) cycle();
    chk("free_cnt3_12", c3, 4);
    chk("free_cnt5_12", c5, 2);
    wait_phase3(1);
    stall = 1'b1;
    repeat (5) begin
      cycle();
      chk("stall_hold3", p3, 3'b010);
    end
    stall = 1'b0;
    chk("stall_cnt3", c3, 4);
    cycle();
    chk("after_stall_p3", p3, 3'b100);
    cycle();
    chk("after_stall_cnt3", c3, 5);
    halt = 1'b1;
    repeat (3) cycle();
    chk("halt_h3", h3, 1);
    chk("halt_p3", p3, 0);
    chk("halt_cnt3", c3, 6);
    cycle();
    chk("halt_stays3", h3, 1);
    halt = 1'b0;
    cycle();
    chk("resume_p3", p3, 3'b001);
    mode = 1'b1;
    repeat (3) cycle();
    chk("step_pre_h3", h3, 1);
    chk("step_pre_cnt3", c3, 7);
    step = 1'b1;
    repeat (10) cycle();
    chk("step1_cnt3", c3, 8);
    chk("step1_h3", h3, 1);
    step = 1'b0;
    repeat (2) cycle();
    step = 1'b1;
    repeat (5) cycle();
    chk("step2_cnt3", c3, 9);
    chk("step2_h3", h3, 1);
    step = 1'b0;
    mode = 1'b0;
    repeat (3000) begin
      stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) halt = ~halt;
      step = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      cycle();
    end
    mode = 1'b0; halt = 1'b0; stall = 1'b0; step = 1'b0;
    repeat (2) cycle();
    wait_phase3(1);
    stall = 1'b1;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_phase3", p3, 1);
    chk("arst_state3", s3, 0);
    chk("arst_last3", l3, 0);
    chk("arst_cnt3", c3, 0);
    chk("arst_halted5", h5, 1);
    chk("arst_cnt5", c5, 0);
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    stall = 1'b0;
    repeat (20) cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
